// File: rtl/config_chain_writer_pkg.sv
// Shared constants and types for the configuration shift-chain master.
package config_chain_writer_pkg;

  localparam int CFG_WORD_LENGTH       = 16;
  localparam int CFG_WORDS_PER_SYNAPSE = 4;
  localparam int CFG_SYNAPSES_PER_CHAIN = 2;
  localparam int CFG_CLK_DIV_DEFAULT   = 2;

  typedef logic [CFG_WORD_LENGTH-1:0] fp_t;

  // Number of config words in a chain of n_syn synapse blocks.
  function automatic int chain_length(input int n_syn);
    return n_syn * CFG_WORDS_PER_SYNAPSE;
  endfunction

  localparam int CFG_CHAIN_LENGTH = chain_length(CFG_SYNAPSES_PER_CHAIN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/config_chain_writer_clk_divider.sv
// Phase timer for data_clk: while enabled, ticks once every CLK_DIV cycles.
// Reloads whenever disabled so each shift starts with a full LOW phase.
module cfg_clk_divider
  import config_chain_writer_pkg::*;
#(
  parameter int CLK_DIV = CFG_CLK_DIV_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == '0);

  // Down-counter: reload on terminal count or when idle, else decrement.
  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (!en_i || tick_o) cnt_d = RELOAD;
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= RELOAD;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/config_chain_writer.sv
// Head of a config shift chain: buffers CHAIN_LENGTH host words, then shifts
// them out in write order with a divided data_clk.
//
// state  | meaning
// IDLE   | accepting host words, waiting for start
// LOW    | data_clk low, data_in presents word[idx]
// HIGH   | data_clk high, data_in held stable
module config_chain_writer
  import config_chain_writer_pkg::*;
#(
  parameter int WORD_LENGTH  = CFG_WORD_LENGTH,
  parameter int CHAIN_LENGTH = CFG_CHAIN_LENGTH,
  parameter int CLK_DIV      = CFG_CLK_DIV_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_valid_i,
  input  logic [WORD_LENGTH-1:0] wr_data_i,
  output logic                   wr_ready_o,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   start_err_o,
  output logic                   cfg_data_clk_o,
  output logic [WORD_LENGTH-1:0] cfg_data_in_o
);

  localparam int CW = $clog2(CHAIN_LENGTH + 1);
  localparam int AW = (CHAIN_LENGTH > 1) ? $clog2(CHAIN_LENGTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(CHAIN_LENGTH);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LENGTH - 1);

  cfg_state_e             state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          idx_q, idx_d;
  logic [WORD_LENGTH-1:0] buf_q [CHAIN_LENGTH];
  logic [WORD_LENGTH-1:0] data_in_q, data_in_d;
  logic                   data_clk_q, data_clk_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   idle, wr_en, phase_end;

  assign idle           = (state_q == ST_IDLE);
  assign wr_ready_o     = idle && (count_q < FULL);
  assign wr_en          = wr_valid_i && wr_ready_o;
  assign busy_o         = !idle;
  assign done_o         = done_q;
  assign start_err_o    = err_q;
  assign cfg_data_clk_o = data_clk_q;
  assign cfg_data_in_o  = data_in_q;

  cfg_clk_divider #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (!idle),
    .tick_o (phase_end)
  );

  // Word buffer, filled in write order; no reset needed since count gates use.
  always_ff @(posedge clk_i) begin
    if (wr_en) buf_q[count_q[AW-1:0]] <= wr_data_i;
  end

  // Next-state and output decode. Start is judged on the pre-write count.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    data_in_d  = data_in_q;
    data_clk_d = data_clk_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (wr_en) count_d = count_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (count_q == FULL) begin
            state_d    = ST_LOW;
            idx_d      = '0;
            data_in_d  = buf_q[0];
            data_clk_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOW: begin
        if (phase_end) begin
          state_d    = ST_HIGH;
          data_clk_d = 1'b1;
        end
      end
      ST_HIGH: begin
        if (phase_end) begin
          data_clk_d = 1'b0;
          if (idx_q < LAST) begin
            idx_d     = idx_q + 1'b1;
            data_in_d = buf_q[idx_d[AW-1:0]];
            state_d   = ST_LOW;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            count_d = '0;
            idx_d   = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered-output flops; reset forces data_clk low at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      idx_q      <= '0;
      data_in_q  <= '0;
      data_clk_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      data_in_q  <= data_in_d;
      data_clk_q <= data_clk_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_config_chain_writer.sv
// Directed bench for config_chain_writer with a 2-synapse chain model.
module tb_config_chain_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic        start = 1'b0;
  logic        wr_ready, busy, done, start_err, data_clk;
  logic [15:0] data_in;

  int checks = 0;
  int errors = 0;

  int edges = 0, busy_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic [15:0] cap   [64];
  logic [15:0] chain [8];

  config_chain_writer dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .wr_valid_i     (wr_valid),
    .wr_data_i      (wr_data),
    .wr_ready_o     (wr_ready),
    .start_i        (start),
    .busy_o         (busy),
    .done_o         (done),
    .start_err_o    (start_err),
    .cfg_data_clk_o (data_clk),
    .cfg_data_in_o  (data_in)
  );

  initial forever #5 clk = ~clk;

  // Chain model: chain[0] nearest stage, chain[7] farthest.
  always @(posedge data_clk) begin
    cap[edges % 64] <= data_in;
    chain[0] <= data_in;
    for (int k = 1; k < 8; k++) chain[k] <= chain[k-1];
    edges <= edges + 1;
  end

  always @(posedge clk) begin
    if (busy)      busy_cnt <= busy_cnt + 1;
    if (done)      done_cnt <= done_cnt + 1;
    if (start_err) err_cnt  <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] w);
    wr_valid = 1'b1;
    wr_data  = w;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      step();
      if (done) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  int e0, b0, d0, r0;

  initial begin
    // Reset values
    #12;
    chk("rst_data_clk", 32'(data_clk), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(start_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rel_wr_ready", 32'(wr_ready), 32'd1);

    // Full load 0x0001..0x0008, overflow word dropped, shift out
    for (int i = 0; i < 8; i++) begin
      chk("load_ready", 32'(wr_ready), 32'd1);
      write_word(16'(i + 1));
    end
    chk("full_ready", 32'(wr_ready), 32'd0);
    write_word(16'hFFFF);
    e0 = edges; b0 = busy_cnt; d0 = done_cnt;
    pulse_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done();
    chk("end_data_clk", 32'(data_clk), 32'd0);
    chk("end_data_in", 32'(data_in), 32'h0008);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_wr_ready", 32'(wr_ready), 32'd1);
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_cycles", 32'(busy_cnt - b0), 32'd32);
    chk("edge_count", 32'(edges - e0), 32'd8);
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < 8; i++) chk("shift_word", 32'(cap[(e0 + i) % 64]), 32'(i + 1));
    chk("chain_far", 32'(chain[7]), 32'h0001);
    chk("chain_near", 32'(chain[0]), 32'h0008);

    // Short load: start rejected, then start together with the last write
    for (int i = 0; i < 7; i++) write_word(16'h00A1 + 16'(i));
    chk("short_ready", 32'(wr_ready), 32'd1);
    e0 = edges; b0 = busy_cnt;
    pulse_start();
    chk("short_err", 32'(start_err), 32'd1);
    chk("short_busy", 32'(busy), 32'd0);
    step();
    chk("short_err_pulse", 32'(start_err), 32'd0);
    chk("short_ready2", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1; wr_data = 16'h00A8; start = 1'b1;
    step();
    wr_valid = 1'b0; start = 1'b0;
    chk("same_cycle_err", 32'(start_err), 32'd1);
    chk("same_cycle_landed", 32'(wr_ready), 32'd0);
    step();
    chk("short_edges", 32'(edges - e0), 32'd0);
    chk("short_busy_cnt", 32'(busy_cnt - b0), 32'd0);

    // Start again while busy: ignored
    e0 = edges; b0 = busy_cnt; r0 = err_cnt;
    pulse_start();
    repeat (5) step();
    pulse_start();
    chk("busy_start_no_err", 32'(start_err), 32'd0);
    wait_done();
    step();
    chk("rs_edges", 32'(edges - e0), 32'd8);
    chk("rs_busy_cycles", 32'(busy_cnt - b0), 32'd32);
    chk("rs_err_cnt", 32'(err_cnt - r0), 32'd0);
    chk("rs_wr_ready", 32'(wr_ready), 32'd1);
    for (int i = 0; i < 8; i++) chk("rs_word", 32'(cap[(e0 + i) % 64]), 32'h00A1 + 32'(i));

    // Reset mid-shift: immediate abort, no done
    for (int i = 0; i < 8; i++) write_word(16'h0101 + 16'(i));
    pulse_start();
    repeat (10) step();
    chk("mid_data_clk_high", 32'(data_clk), 32'd1);
    chk("mid_busy", 32'(busy), 32'd1);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_data_clk", 32'(data_clk), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_wr_ready", 32'(wr_ready), 32'd1);

    // Reload and clean shift
    for (int i = 0; i < 8; i++) write_word(16'h0201 + 16'(i));
    e0 = edges; b0 = busy_cnt;
    pulse_start();
    wait_done();
    step();
    chk("reload_edges", 32'(edges - e0), 32'd8);
    chk("reload_busy_cycles", 32'(busy_cnt - b0), 32'd32);
    for (int i = 0; i < 8; i++) chk("reload_word", 32'(cap[(e0 + i) % 64]), 32'h0201 + 32'(i));
    chk("reload_chain_far", 32'(chain[7]), 32'h0201);
    chk("reload_chain_near", 32'(chain[0]), 32'h0208);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
